// File: rtl/aes_128_sched_pkg.sv
// Shared types and constants for the two-requester AES-128 issue scheduler.
package aes_sched_pkg;

  // One bit is enough to name either of the two requesters.
  localparam int REQ_ID_W = 1;

  // Default pipeline depth of the external aes_128 core, in clock cycles.
  localparam int DEF_LATENCY = 21;

  // Tag that travels alongside each block through the core pipeline.
  typedef struct packed {
    logic                valid;
    logic [REQ_ID_W-1:0] id;
  } tag_t;

  // Turn a requester id into its one-hot strobe position.
  function automatic logic [1:0] idToOneHot(input logic [REQ_ID_W-1:0] id);
    return id[0] ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/aes_128_sched_arb.sv
// Two-way round-robin arbiter. The pointer names the requester that wins a
// tie; it moves to the other requester after every completed transfer.
module rr_arb2
  import aes_sched_pkg::*;
(
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                en_i,
  input  logic [1:0]          reqValid_i,
  output logic [1:0]          grant_o,
  output logic [REQ_ID_W-1:0] grantId_o,
  output logic                transfer_o
);

  logic [REQ_ID_W-1:0] ptr_q;
  logic [REQ_ID_W-1:0] ptr_d;

  // Grant is purely combinational; reset and a low enable both force no grant.
  always_comb begin
    grant_o = 2'b00;
    if (en_i && !rst_i) begin
      case (reqValid_i)
        2'b01:   grant_o = 2'b01;
        2'b10:   grant_o = 2'b10;
        2'b11:   grant_o = ptr_q[0] ? 2'b10 : 2'b01;
        default: grant_o = 2'b00;
      endcase
    end
  end

  // A grant is only ever given to a valid requester, so any grant is a transfer.
  always_comb begin
    transfer_o = |grant_o;
    grantId_o  = grant_o[1];
    ptr_d      = transfer_o ? ~grantId_o : ptr_q;
  end

  // Pointer register; after reset requester 0 wins the first tie.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/aes_128_sched.sv
// Issue scheduler in front of an external pipelined aes_128 core: arbitrates
// two requesters, tracks which requester owns each block in the pipeline and
// steers the ciphertext back as a one-hot response strobe.
module aes_128_sched
  import aes_sched_pkg::*;
#(
  parameter int LATENCY = DEF_LATENCY,
  parameter int CNT_W   = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         en,
  input  logic [1:0]                   req_valid,
  output logic [1:0]                   req_ready,
  input  logic [127:0]                 req_state0,
  input  logic [127:0]                 req_state1,
  input  logic [127:0]                 req_key0,
  input  logic [127:0]                 req_key1,
  output logic [127:0]                 core_state,
  output logic [127:0]                 core_key,
  input  logic [127:0]                 core_out,
  output logic [1:0]                   resp_valid,
  output logic [127:0]                 resp_data,
  output logic [$clog2(LATENCY+1)-1:0] inflight,
  output logic [CNT_W-1:0]             issued0,
  output logic [CNT_W-1:0]             issued1,
  output logic                         busy
);

  localparam int INF_W = $clog2(LATENCY+1);

  logic [1:0]          grant;
  logic [REQ_ID_W-1:0] grantId;
  logic                transfer;

  tag_t tag_q [LATENCY];
  tag_t tag_d [LATENCY];
  tag_t tagOut;

  logic [INF_W-1:0] inflight_q, inflight_d;
  logic [CNT_W-1:0] issued0_q, issued0_d;
  logic [CNT_W-1:0] issued1_q, issued1_d;

  rr_arb2 u_arb (
    .clk_i      (clk),
    .rst_i      (rst),
    .en_i       (en),
    .reqValid_i (req_valid),
    .grant_o    (grant),
    .grantId_o  (grantId),
    .transfer_o (transfer)
  );

  // Granted requester's block goes straight to the core in the grant cycle.
  always_comb begin
    req_ready  = grant;
    core_state = '0;
    core_key   = '0;
    if (grant[0]) begin
      core_state = req_state0;
      core_key   = req_key0;
    end else if (grant[1]) begin
      core_state = req_state1;
      core_key   = req_key1;
    end
  end

  // Tag pipeline next state: a new tag enters on a transfer, everything shifts.
  always_comb begin
    tag_d[0].valid = transfer;
    tag_d[0].id    = transfer ? grantId : '0;
    for (int i = 1; i < LATENCY; i++) begin
      tag_d[i] = tag_q[i-1];
    end
  end

  // Tag pipeline register, running in lockstep with the core pipeline.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < LATENCY; i++) begin
        tag_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < LATENCY; i++) begin
        tag_q[i] <= tag_d[i];
      end
    end
  end

  // The last tag stage lines up with core_out and selects the response owner.
  always_comb begin
    tagOut     = tag_q[LATENCY-1];
    resp_valid = tagOut.valid ? idToOneHot(tagOut.id) : 2'b00;
    resp_data  = tagOut.valid ? core_out : '0;
  end

  // Occupancy and per-requester issue counters; an entry and an exit cancel.
  always_comb begin
    inflight_d = inflight_q;
    case ({transfer, tagOut.valid})
      2'b10:   inflight_d = inflight_q + 1'b1;
      2'b01:   inflight_d = inflight_q - 1'b1;
      default: inflight_d = inflight_q;
    endcase
    issued0_d = (transfer && grantId == 1'b0) ? issued0_q + 1'b1 : issued0_q;
    issued1_d = (transfer && grantId == 1'b1) ? issued1_q + 1'b1 : issued1_q;
  end

  // Counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inflight_q <= '0;
      issued0_q  <= '0;
      issued1_q  <= '0;
    end else begin
      inflight_q <= inflight_d;
      issued0_q  <= issued0_d;
      issued1_q  <= issued1_d;
    end
  end

  assign inflight = inflight_q;
  assign issued0  = issued0_q;
  assign issued1  = issued1_q;
  assign busy     = (inflight_q != '0);

endmodule

// File: tb/tb_aes_128_sched.sv
// Randomized self-checking bench for aes_128_sched. A stand-in aes_128 core
// (a plain delay line with a few known FIPS-197 answers) sits behind the DUT.
module tb_aes_128_sched;

  localparam int LAT = 21;

  localparam logic [127:0] V1S = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] V1K = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] V1C = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] V2S = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] V2K = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] V2C = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         en = 1'b0;
  logic [1:0]   req_valid = 2'b00;
  logic [127:0] req_state0 = '0, req_state1 = '0, req_key0 = '0, req_key1 = '0;
  logic [1:0]   req_ready;
  logic [127:0] core_state, core_key, core_out;
  logic [1:0]   resp_valid;
  logic [127:0] resp_data;
  logic [4:0]   inflight;
  logic [15:0]  issued0, issued1;
  logic         busy;

  logic [1:0]   d4Ready, d4RespValid;
  logic [127:0] d4CoreState, d4CoreKey, d4RespData;
  logic [4:0]   d4Inflight;
  logic [3:0]   d4Issued0, d4Issued1;
  logic         d4Busy;

  int errCnt = 0;
  int checkCnt = 0;
  int cycleNo = 0;

  // Reference model state: who won last, how many each side got, and the
  // responses still owed, in issue order, each with the cycle it is due in.
  typedef struct {
    int           due;
    logic [1:0]   vld;
    logic [127:0] data;
  } resp_t;
  resp_t respQ[$];
  int    lastGrant = 1;
  int    issuedCnt0 = 0;
  int    issuedCnt1 = 0;

  aes_128_sched #(.LATENCY(LAT), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .en(en), .req_valid(req_valid), .req_ready(req_ready),
    .req_state0(req_state0), .req_state1(req_state1),
    .req_key0(req_key0), .req_key1(req_key1),
    .core_state(core_state), .core_key(core_key), .core_out(core_out),
    .resp_valid(resp_valid), .resp_data(resp_data), .inflight(inflight),
    .issued0(issued0), .issued1(issued1), .busy(busy)
  );

  // Narrow-counter copy, used to see the issue counters wrap quickly.
  aes_128_sched #(.LATENCY(LAT), .CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .en(en), .req_valid(req_valid), .req_ready(d4Ready),
    .req_state0(req_state0), .req_state1(req_state1),
    .req_key0(req_key0), .req_key1(req_key1),
    .core_state(d4CoreState), .core_key(d4CoreKey), .core_out(core_out),
    .resp_valid(d4RespValid), .resp_data(d4RespData), .inflight(d4Inflight),
    .issued0(d4Issued0), .issued1(d4Issued1), .busy(d4Busy)
  );

  // 100 MHz-style free-running clock.
  always #5 clk = ~clk;

  // Stand-in cipher: known vectors give the real answer, anything else a mix.
  function automatic logic [127:0] fakeAes(input logic [127:0] s, input logic [127:0] k);
    if (s == V1S && k == V1K) return V1C;
    if (s == V2S && k == V2K) return V2C;
    return s ^ {k[63:0], k[127:64]} ^ 128'h5a5a_0f0f_3c3c_a5a5_1234_5678_9abc_def0;
  endfunction

  // Stand-in core pipeline: samples state/key each edge, answers LAT cycles on.
  logic [127:0] pipeS [LAT];
  logic [127:0] pipeK [LAT];
  always @(posedge clk) begin
    pipeS[0] <= core_state;
    pipeK[0] <= core_key;
    for (int i = 1; i < LAT; i++) begin
      pipeS[i] <= pipeS[i-1];
      pipeK[i] <= pipeK[i-1];
    end
  end
  assign core_out = fakeAes(pipeS[LAT-1], pipeK[LAT-1]);

  function automatic logic [127:0] randBlock();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Round-robin rule: a lone requester wins; on a tie the one not granted last.
  function automatic logic [1:0] modelGrant(input logic [1:0] v, input logic e);
    if (!e) return 2'b00;
    if (v == 2'b01) return 2'b01;
    if (v == 2'b10) return 2'b10;
    if (v == 2'b11) return (lastGrant == 0) ? 2'b10 : 2'b01;
    return 2'b00;
  endfunction

  task automatic checkOutput(input string tag, input logic [127:0] actual, input logic [127:0] expected);
    checkCnt++;
    if (actual !== expected) begin
      errCnt++;
      $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", tag, actual, expected, cycleNo);
    end
  endtask

  // One clock cycle: drive inputs, check everything against the model, step.
  task automatic applyStimulus(input logic [1:0] v, input logic e,
                               input logic [127:0] s0, input logic [127:0] k0,
                               input logic [127:0] s1, input logic [127:0] k1);
    logic [1:0]   expGrant;
    logic [127:0] expS, expK;
    resp_t        ent;
    req_valid  = v;
    en         = e;
    req_state0 = s0;
    req_key0   = k0;
    req_state1 = s1;
    req_key1   = k1;
    #1;
    expGrant = modelGrant(v, e);
    expS = expGrant[0] ? s0 : (expGrant[1] ? s1 : 128'h0);
    expK = expGrant[0] ? k0 : (expGrant[1] ? k1 : 128'h0);
    checkOutput("req_ready", 128'(req_ready), 128'(expGrant));
    checkOutput("core_state", core_state, expS);
    checkOutput("core_key", core_key, expK);
    if (respQ.size() > 0 && respQ[0].due == cycleNo) begin
      ent = respQ[0];
      checkOutput("resp_valid", 128'(resp_valid), 128'(ent.vld));
      checkOutput("resp_data", resp_data, ent.data);
      checkOutput("d4_resp_valid", 128'(d4RespValid), 128'(ent.vld));
    end else begin
      checkOutput("resp_valid_idle", 128'(resp_valid), 128'h0);
    end
    checkOutput("inflight", 128'(inflight), 128'(respQ.size()));
    checkOutput("busy", 128'(busy), 128'(respQ.size() != 0));
    checkOutput("issued0", 128'(issued0), 128'(issuedCnt0 % 65536));
    checkOutput("issued1", 128'(issued1), 128'(issuedCnt1 % 65536));
    checkOutput("d4_issued0", 128'(d4Issued0), 128'(issuedCnt0 % 16));
    if (respQ.size() > 0 && respQ[0].due == cycleNo) void'(respQ.pop_front());
    @(posedge clk);
    if (expGrant != 2'b00) begin
      ent.due  = cycleNo + LAT;
      ent.vld  = expGrant;
      ent.data = expGrant[0] ? fakeAes(s0, k0) : fakeAes(s1, k1);
      respQ.push_back(ent);
      lastGrant = expGrant[1] ? 1 : 0;
      if (expGrant[0]) issuedCnt0++;
      else issuedCnt1++;
    end
    cycleNo++;
    @(negedge clk);
  endtask

  // Hold reset for two edges with both requesters pushing; nothing may be granted.
  task automatic doReset();
    rst       = 1'b1;
    en        = 1'b1;
    req_valid = 2'b11;
    #1;
    checkOutput("rst_ready", 128'(req_ready), 128'h0);
    repeat (2) @(posedge clk);
    cycleNo += 2;
    @(negedge clk);
    checkOutput("rst_resp_valid", 128'(resp_valid), 128'h0);
    checkOutput("rst_inflight", 128'(inflight), 128'h0);
    checkOutput("rst_busy", 128'(busy), 128'h0);
    checkOutput("rst_issued0", 128'(issued0), 128'h0);
    checkOutput("rst_issued1", 128'(issued1), 128'h0);
    respQ.delete();
    lastGrant  = 1;
    issuedCnt0 = 0;
    issuedCnt1 = 0;
    rst        = 1'b0;
    req_valid  = 2'b00;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(2'b00, 1'b1, '0, '0, '0, '0);
  endtask

  // Main sequence of scenarios.
  initial begin
    @(negedge clk);
    doReset();

    // Single known-answer block from requester 0.
    applyStimulus(2'b01, 1'b1, V1S, V1K, '0, '0);
    idle(LAT + 3);

    // Both requesters for 8 cycles: grants alternate, requester 1 known answer.
    doReset();
    for (int i = 0; i < 8; i++) applyStimulus(2'b11, 1'b1, randBlock(), randBlock(), V2S, V2K);
    checkOutput("tie_issued0", 128'(issuedCnt0), 128'd4);
    idle(LAT + 2);

    // Long back-to-back stream fills the pipeline and holds it full.
    for (int i = 0; i < LAT + 10; i++) applyStimulus(2'b01, 1'b1, randBlock(), randBlock(), '0, '0);
    idle(LAT + 2);

    // Enable drops after five transfers; all five still drain.
    for (int i = 0; i < 5; i++) applyStimulus(2'b10, 1'b1, '0, '0, randBlock(), randBlock());
    for (int i = 0; i < LAT + 3; i++) applyStimulus(2'b11, 1'b0, randBlock(), randBlock(), randBlock(), randBlock());

    // Reset with ten blocks in flight: nothing may come back afterwards.
    for (int i = 0; i < 10; i++) applyStimulus(2'b11, 1'b1, randBlock(), randBlock(), randBlock(), randBlock());
    doReset();
    idle(LAT + 3);

    // Random traffic with occasional enable drops.
    for (int i = 0; i < 200; i++)
      applyStimulus(2'($urandom_range(0, 3)), ($urandom_range(0, 7) != 0),
                    randBlock(), randBlock(), randBlock(), randBlock());
    idle(LAT + 2);

    // Sixteen requester-0 transfers wrap the 4-bit counter back to zero.
    doReset();
    for (int i = 0; i < 16; i++) applyStimulus(2'b01, 1'b1, randBlock(), randBlock(), '0, '0);
    checkOutput("wrap_d4_issued0", 128'(d4Issued0), 128'h0);
    checkOutput("wrap_issued0", 128'(issued0), 128'd16);
    idle(LAT + 2);

    $display("Result: errors=%0d of %0d checks", errCnt, checkCnt);
    $finish;
  end

endmodule
